password_sender: RTL

Serial transmitter for the password checking path. It latches a parallel code and shifts it out one bit per clock as a framed sequence: start marker, code MSB-first, then even parity. It then waits for the checker's verdict, counts failed attempts and locks out after too many failures. It is the sending end of the serial password interface, and each output bit is registered by D flip-flops on clk.

---
 rtl/password_sender.sv | 123 ++++++++++++
 1 files changed

// File: rtl/password_sender.sv
// Serial password transmitter: sends start marker, code MSB-first and even parity,
// then waits for the checker's verdict and counts failed attempts up to a lockout.
`timescale 1ns/1ps
module password_sender #(
    parameter int CODE_W       = 8,
    parameter int MAX_TRIES    = 3,
    parameter int RESP_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    output logic              tx_d,
    output logic              tx_valid,
    input  logic              resp_valid,
    input  logic              resp_ok,
    output logic              busy,
    output logic              done,
    output logic              granted,
    output logic              locked,
    output logic [1:0]        tries
);
    localparam int               CNT_W    = $clog2(CODE_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CODE_W - 1);
    localparam logic [7:0]       TMO_LAST = 8'(RESP_TIMEOUT - 1);
    localparam logic [1:0]       MAX_T    = 2'(MAX_TRIES);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, WAIT, DONE, LOCKED} state_t;

    state_t            state;
    logic [CODE_W-1:0] shreg;
    logic              parity;
    logic [CNT_W-1:0]  bit_cnt;
    logic [7:0]        tmo_cnt;
    logic [1:0]        next_tries;

    assign next_tries = (tries == 2'd3) ? 2'd3 : tries + 2'd1;

    // Each output is registered together with the state it belongs to, so tx_d/tx_valid
    // are loaded on the edge that enters a frame slot rather than decoded from state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            parity   <= 1'b0;
            bit_cnt  <= '0;
            tmo_cnt  <= '0;
            tx_d     <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            granted  <= 1'b0;
            locked   <= 1'b0;
            tries    <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !locked) begin
                        shreg    <= code;
                        parity   <= ^code;
                        granted  <= 1'b0;
                        busy     <= 1'b1;
                        tx_d     <= 1'b1;
                        tx_valid <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_d    <= shreg[CODE_W-1];
                    shreg   <= shreg << 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        tx_d  <= parity;
                        state <= PARITY;
                    end else begin
                        tx_d    <= shreg[CODE_W-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    tx_d     <= 1'b0;
                    tx_valid <= 1'b0;
                    tmo_cnt  <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A verdict arriving on the timeout cycle takes precedence over the timeout.
                    if (resp_valid || (tmo_cnt == TMO_LAST)) begin
                        done <= 1'b1;
                        if (resp_valid && resp_ok) begin
                            granted <= 1'b1;
                            tries   <= 2'd0;
                            state   <= DONE;
                        end else begin
                            tries <= next_tries;
                            if (next_tries == MAX_T) begin
                                locked <= 1'b1;
                                busy   <= 1'b0;
                                state  <= LOCKED;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                LOCKED: begin
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
